triple_buffer_reader: RTL and testbench

Read-side controller and buffer arbiter for the three-frame ETS capture buffer. It tracks which frame buffer holds the newest complete frame and hands the writer a free one-hot buffer ID. It also sweeps the read port of the newest frame, 0..MAX_TAP-1, and streams the words out as AXI-Stream with backpressure, so a frame being read is never overwritten.

---
 rtl/triple_buffer_reader.sv | 123 ++++++++++++
 tb/tb_triple_buffer_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/triple_buffer_reader.sv
// triple_buffer_reader: three-frame buffer arbiter plus AXI-Stream reader of the newest complete frame
module triple_buffer_reader #(
  parameter int MAX_TAP = 448,
  parameter int RD_LATENCY = 1
) (
  input  logic        r_clk,
  input  logic        rst_n,
  input  logic        w_done,
  input  logic [2:0]  w_done_id,
  output logic [2:0]  w_buffer_id,
  output logic [2:0]  r_buffer_id,
  output logic [8:0]  raddr,
  output logic        r_occur,
  input  logic [31:0] rdata,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] drop_cnt,
  output logic        id_err
);
  localparam logic [8:0] LAST = 9'(MAX_TAP - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nx;
  logic [2:0] latest, latest_nx, reading, reading_nx, occ, wbuf_nx;
  logic fresh, fresh_nx, start, accept, drop_inc, issue, pop, capture;
  logic [8:0] issue_cnt, issue_nx, beat_cnt, beat_nx;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [31:0] fifo [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt, in_flight;
  logic [3:0] outstanding;
  assign r_buffer_id = reading;
  assign capture = rd_pipe[RD_LATENCY-1];
  assign m_axis_tvalid = fifo_cnt != 3'd0;
  assign m_axis_tdata = fifo[rd_ptr];
  assign m_axis_tlast = m_axis_tvalid && beat_cnt == LAST;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign outstanding = {1'b0, fifo_cnt} + {1'b0, in_flight} - {3'b0, pop};
  // count reads issued but not yet landed in the FIFO
  always_comb begin
    in_flight = {2'b0, r_occur};
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + {2'b0, rd_pipe[i]};
  end
  // frame sequencer: pick up the newest frame, issue its addresses under credit, drain the stream
  always_comb begin
    state_nx = state;
    reading_nx = reading;
    issue_nx = issue_cnt;
    beat_nx = pop ? beat_cnt + 9'd1 : beat_cnt;
    start = 1'b0;
    issue = 1'b0;
    case (state)
      IDLE: if (fresh) begin
        start = 1'b1;
        reading_nx = latest;
        issue_nx = '0;
        beat_nx = '0;
        state_nx = ISSUE;
      end
      ISSUE: if (outstanding < 4'd4) begin
        issue = 1'b1;
        issue_nx = issue_cnt + 9'd1;
        state_nx = issue_cnt == LAST ? DRAIN : ISSUE;
      end
      DRAIN: if (pop && m_axis_tlast) begin
        reading_nx = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // buffer arbitration: a completed frame becomes latest; writer gets the lowest buffer nobody holds
  always_comb begin
    accept = w_done && w_done_id == w_buffer_id;
    latest_nx = accept ? w_done_id : latest;
    fresh_nx = accept || (fresh && !start);
    drop_inc = accept && fresh && !start;
    occ = latest_nx | reading_nx;
    wbuf_nx = !occ[0] ? 3'b001 : !occ[1] ? 3'b010 : !occ[2] ? 3'b100 : 3'b000;
  end
  // control and bookkeeping registers
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      latest <= '0;
      fresh <= 1'b0;
      reading <= '0;
      w_buffer_id <= 3'b001;
      issue_cnt <= '0;
      beat_cnt <= '0;
      raddr <= '0;
      r_occur <= 1'b0;
      drop_cnt <= '0;
      id_err <= 1'b0;
      rd_pipe <= '0;
      fifo_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nx;
      latest <= latest_nx;
      fresh <= fresh_nx;
      reading <= reading_nx;
      w_buffer_id <= wbuf_nx;
      issue_cnt <= issue_nx;
      beat_cnt <= beat_nx;
      raddr <= issue ? issue_cnt : raddr;
      r_occur <= issue;
      drop_cnt <= drop_inc && drop_cnt != 16'hFFFF ? drop_cnt + 16'd1 : drop_cnt;
      id_err <= id_err || (w_done && !accept);
      rd_pipe[0] <= r_occur;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      fifo_cnt <= fifo_cnt + {2'b0, capture} - {2'b0, pop};
      wr_ptr <= wr_ptr + {1'b0, capture};
      rd_ptr <= rd_ptr + {1'b0, pop};
    end
  end
  // output FIFO storage; contents are don't-care while empty
  always_ff @(posedge r_clk) begin
    if (capture) fifo[wr_ptr] <= rdata;
  end
endmodule

// File: tb/tb_triple_buffer_reader.sv
// tb_triple_buffer_reader: directed stimulus with a frame-level reference model and per-cycle compare
module tb_triple_buffer_reader;
  localparam int MAX_TAP = 448;
  logic r_clk, rst_n, w_done, r_occur, m_axis_tvalid, m_axis_tready, m_axis_tlast, id_err;
  logic [2:0] w_done_id, w_buffer_id, r_buffer_id;
  logic [8:0] raddr;
  logic [31:0] rdata, m_axis_tdata;
  logic [15:0] drop_cnt;
  int total = 0;
  int bad = 0;
  logic rnd = 1'b0;
  logic [2:0] m_latest, m_reading, m_wbuf, m_occ;
  logic m_fresh, m_busy, m_err, p_stall, p_last, hs, st, acc;
  logic [15:0] m_drop;
  logic [31:0] p_data;
  logic [8:0] bx;
  int m_beats, m_issued;
  int m_frames = 0;

  triple_buffer_reader #(.MAX_TAP(MAX_TAP), .RD_LATENCY(1)) dut (
    .r_clk(r_clk), .rst_n(rst_n), .w_done(w_done), .w_done_id(w_done_id),
    .w_buffer_id(w_buffer_id), .r_buffer_id(r_buffer_id), .raddr(raddr), .r_occur(r_occur),
    .rdata(rdata), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .drop_cnt(drop_cnt), .id_err(id_err)
  );

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  // buffer memory: word encodes the buffer it came from and its address, one-cycle read latency
  always @(posedge r_clk) if (r_occur) rdata <= {r_buffer_id, 20'h0, raddr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: frame-level rules, checked every negedge, advanced with the inputs of the coming edge
  always @(negedge r_clk) begin
    if (!rst_n) begin
      m_latest = '0; m_fresh = 0; m_reading = '0; m_busy = 0; m_wbuf = 3'b001;
      m_drop = '0; m_err = 0; m_beats = 0; m_issued = 0; p_stall = 0;
    end
    chk("w_buffer_id", 32'(w_buffer_id), 32'(m_wbuf));
    chk("r_buffer_id", 32'(r_buffer_id), 32'(m_reading));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("id_err", 32'(id_err), 32'(m_err));
    if (!rst_n) begin
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_r_occur", 32'(r_occur), 32'd0);
      chk("rst_raddr", 32'(raddr), 32'd0);
    end else begin
      if (r_occur) begin
        chk("occur_busy", 32'(m_busy), 32'd1);
        chk("raddr", 32'(raddr), 32'(m_issued));
        m_issued++;
      end
      chk("credit", 32'((m_issued - m_beats) <= 4), 32'd1);
      if (p_stall) begin
        chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_data", m_axis_tdata, p_data);
        chk("stall_last", 32'(m_axis_tlast), 32'(p_last));
      end
      if (m_axis_tvalid) begin
        bx = 9'(m_beats);
        chk("tdata", m_axis_tdata, {m_reading, 20'h0, bx});
        chk("tlast", 32'(m_axis_tlast), 32'(m_beats == MAX_TAP - 1));
      end
      p_stall = m_axis_tvalid && !m_axis_tready;
      p_data = m_axis_tdata;
      p_last = m_axis_tlast;
      hs = m_axis_tvalid && m_axis_tready;
      st = !m_busy && m_fresh;
      acc = w_done && w_done_id == m_wbuf;
      if (hs) m_beats++;
      if (m_busy && hs && m_beats == MAX_TAP) begin
        chk("frame_issues", 32'(m_issued), 32'(MAX_TAP));
        m_busy = 0; m_reading = '0; m_frames++;
      end
      if (st) begin
        m_reading = m_latest; m_busy = 1; m_beats = 0; m_issued = 0;
      end
      if (acc) begin
        if (m_fresh && !st && m_drop != 16'hFFFF) m_drop++;
        m_latest = w_done_id;
      end else if (w_done) m_err = 1;
      m_fresh = acc ? 1'b1 : st ? 1'b0 : m_fresh;
      m_occ = m_latest | m_reading;
      m_wbuf = !m_occ[0] ? 3'b001 : !m_occ[1] ? 3'b010 : !m_occ[2] ? 3'b100 : 3'b000;
    end
  end

  task automatic tick();
    @(posedge r_clk);
    #2;
  endtask

  task automatic pulse(input logic [2:0] id);
    w_done = 1'b1;
    w_done_id = id;
    tick();
    w_done = 1'b0;
    w_done_id = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy || m_fresh) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(m_busy || m_fresh), 32'd0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (m_frames < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_timeout", 32'(m_frames >= target), 32'd1);
  endtask

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge r_clk);
      #2;
      m_axis_tready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  initial begin
    int f0, n;
    rst_n = 1'b0; w_done = 1'b0; w_done_id = '0;
    repeat (3) tick();
    chk("reset_wbuf", 32'(w_buffer_id), 32'h1);
    chk("reset_rbuf", 32'(r_buffer_id), 32'h0);
    chk("reset_tlast", 32'(m_axis_tlast), 32'h0);
    chk("reset_drop", 32'(drop_cnt), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();
    // first frame with tready high, plus two completions while it is read
    pulse(3'b001);
    chk("wbuf_after_done", 32'(w_buffer_id), 32'h2);
    chk("occur_early", 32'(r_occur), 32'h0);
    tick();
    chk("rbuf_start", 32'(r_buffer_id), 32'h1);
    chk("occur_early2", 32'(r_occur), 32'h0);
    tick();
    chk("first_occur", 32'(r_occur), 32'h1);
    chk("first_raddr", 32'(raddr), 32'h0);
    tick();
    chk("tvalid_early", 32'(m_axis_tvalid), 32'h0);
    tick();
    chk("first_tvalid", 32'(m_axis_tvalid), 32'h1);
    chk("first_tdata", m_axis_tdata, 32'h2000_0000);
    chk("first_tlast", 32'(m_axis_tlast), 32'h0);
    repeat (20) tick();
    pulse(3'b010);
    chk("wbuf_skip_reading", 32'(w_buffer_id), 32'h4);
    pulse(3'b100);
    chk("wbuf_back_to_010", 32'(w_buffer_id), 32'h2);
    chk("drop_one", 32'(drop_cnt), 32'h1);
    wait_frames(1, 2000);
    // second frame (buffer 100) under random backpressure
    rnd = 1'b1;
    wait_idle(8000);
    rnd = 1'b0;
    chk("idle_rbuf", 32'(r_buffer_id), 32'h0);
    chk("idle_wbuf", 32'(w_buffer_id), 32'h1);
    // completion on the same edge as the frame start
    pulse(3'b001);
    pulse(3'b010);
    chk("simul_rbuf", 32'(r_buffer_id), 32'h1);
    chk("simul_wbuf", 32'(w_buffer_id), 32'h4);
    chk("simul_drop", 32'(drop_cnt), 32'h1);
    f0 = m_frames;
    wait_frames(f0 + 1, 2000);
    tick();
    chk("simul_second", 32'(r_buffer_id), 32'h2);
    wait_idle(3000);
    // mismatched completion id
    pulse(3'b001);
    repeat (3) tick();
    chk("pre_err_wbuf", 32'(w_buffer_id), 32'h2);
    pulse(3'b100);
    chk("id_err_set", 32'(id_err), 32'h1);
    chk("err_wbuf", 32'(w_buffer_id), 32'h2);
    wait_idle(3000);
    repeat (5) tick();
    chk("err_no_frame", 32'(r_buffer_id), 32'h0);
    chk("err_no_occur", 32'(r_occur), 32'h0);
    // asynchronous reset in the middle of a frame
    pulse(3'b010);
    n = 0;
    while (m_beats < 200 && n < 2000) begin
      tick();
      n++;
    end
    chk("beat200_timeout", 32'(m_beats >= 200), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_wbuf", 32'(w_buffer_id), 32'h1);
    chk("async_rbuf", 32'(r_buffer_id), 32'h0);
    chk("async_raddr", 32'(raddr), 32'h0);
    chk("async_occur", 32'(r_occur), 32'h0);
    chk("async_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("async_tlast", 32'(m_axis_tlast), 32'h0);
    chk("async_drop", 32'(drop_cnt), 32'h0);
    chk("async_err", 32'(id_err), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pulse(3'b001);
    tick();
    tick();
    chk("restart_occur", 32'(r_occur), 32'h1);
    chk("restart_raddr", 32'(raddr), 32'h0);
    chk("restart_rbuf", 32'(r_buffer_id), 32'h1);
    wait_idle(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
